// File: rtl/segre_pkg.sv
// +----------------------------------------------------------------------------
// | segre_pkg : shared icache geometry and fill FSM state encoding
// | rev 1.0
// +----------------------------------------------------------------------------
`default_nettype none

package segre_pkg;

  localparam int ICACHE_NUM_WAYS       = 2;
  localparam int ICACHE_NUM_SETS       = 16;
  localparam int ICACHE_LANE_BYTES     = 16;
  localparam int ICACHE_FILL_BEAT_BITS = 32;

  localparam int ICACHE_OFFSET_SIZE = $clog2(ICACHE_LANE_BYTES);
  localparam int ICACHE_INDEX_SIZE  = $clog2(ICACHE_NUM_SETS);

  typedef enum logic [1:0] {
    IFILL_IDLE = 2'd0,
    IFILL_FILL = 2'd1,
    IFILL_DONE = 2'd2
  } icache_fill_state_e;

endpackage

`default_nettype wire

// File: rtl/segre_icache_fill_fsm.sv
// +----------------------------------------------------------------------------
// | segre_icache_fill_fsm : multi-beat line fill sequencer (state, beat count,
// |                         latched set/way, beat handshake and done pulse)
// | rev 1.0
// +----------------------------------------------------------------------------
`default_nettype none

module segre_icache_fill_fsm
  import segre_pkg::*;
#(
  parameter  int SET_W = 4,
  parameter  int WAY_W = 1,
  parameter  int BEATS = 4,
  localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             fill_start_i,
  input  logic [SET_W-1:0] fill_set_i,
  input  logic [WAY_W-1:0] fill_way_i,
  input  logic             fill_beat_valid_i,
  output logic             fill_beat_ready_o,
  output logic             fill_done_o,
  output logic             busy_o,
  output logic             beat_we_o,
  output logic [SET_W-1:0] fill_set_o,
  output logic [WAY_W-1:0] fill_way_o,
  output logic [CNT_W-1:0] beat_cnt_o
);

  icache_fill_state_e r_state, w_state_nxt;
  logic [CNT_W-1:0]   r_cnt;
  logic [SET_W-1:0]   r_set;
  logic [WAY_W-1:0]   r_way;
  logic               w_last;

  assign w_last    = (r_cnt == CNT_W'(BEATS - 1));
  assign beat_we_o = fill_beat_ready_o & fill_beat_valid_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= IFILL_IDLE;
      r_cnt   <= '0;
      r_set   <= '0;
      r_way   <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == IFILL_IDLE && fill_start_i) begin
        r_set <= fill_set_i;
        r_way <= fill_way_i;
        r_cnt <= '0;
      end else if (beat_we_o) begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IFILL_IDLE: if (fill_start_i) w_state_nxt = IFILL_FILL;
      IFILL_FILL: if (beat_we_o && w_last) w_state_nxt = IFILL_DONE;
      IFILL_DONE: w_state_nxt = IFILL_IDLE;
      default:    w_state_nxt = IFILL_IDLE;
    endcase
  end

  always_comb begin
    fill_beat_ready_o = 1'b0;
    fill_done_o       = 1'b0;
    busy_o            = 1'b1;
    case (r_state)
      IFILL_IDLE: busy_o            = 1'b0;
      IFILL_FILL: fill_beat_ready_o = 1'b1;
      IFILL_DONE: fill_done_o       = 1'b1;
      default:    busy_o            = 1'b0;
    endcase
  end

  assign fill_set_o = r_set;
  assign fill_way_o = r_way;
  assign beat_cnt_o = r_cnt;

endmodule

`default_nettype wire

// File: rtl/segre_icache_data_nway.sv
// +----------------------------------------------------------------------------
// | segre_icache_data_nway : N-way icache data array, multi-beat fill, word
// |                          read with one-cycle latency.
// | Optional byte parity: define SEGRE_ICACHE_PARITY_EN
// | rev 1.0
// +----------------------------------------------------------------------------
`default_nettype none

module segre_icache_data_nway
  import segre_pkg::*;
#(
  parameter  int WORD_SIZE      = 32,
  parameter  int NUM_WAYS       = ICACHE_NUM_WAYS,
  parameter  int NUM_SETS       = ICACHE_NUM_SETS,
  parameter  int LANE_BYTES     = ICACHE_LANE_BYTES,
  parameter  int FILL_BEAT_BITS = ICACHE_FILL_BEAT_BITS,
  localparam int WAY_W          = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      rd_req_i,
  input  logic [WORD_SIZE-1:0]      rd_addr_i,
  input  logic [WAY_W-1:0]          rd_way_i,
  output logic                      rd_ready_o,
  output logic                      rd_valid_o,
  output logic [WORD_SIZE-1:0]      rd_data_o,
  input  logic                      fill_start_i,
  input  logic [WORD_SIZE-1:0]      fill_addr_i,
  input  logic [WAY_W-1:0]          fill_way_i,
  input  logic                      fill_beat_valid_i,
  input  logic [FILL_BEAT_BITS-1:0] fill_beat_data_i,
  output logic                      fill_beat_ready_o,
  output logic                      fill_done_o,
  output logic                      busy_o,
  output logic                      parity_err_o
);

  localparam int OFF        = $clog2(LANE_BYTES);
  localparam int IDX        = $clog2(NUM_SETS);
  localparam int LINE_BITS  = LANE_BYTES * 8;
  localparam int BEATS      = LINE_BITS / FILL_BEAT_BITS;
  localparam int CNT_W      = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int BEAT_BYTES = FILL_BEAT_BITS / 8;
  localparam int WORD_BYTES = WORD_SIZE / 8;
  localparam int WSEL_W     = (OFF > 2) ? OFF - 2 : 1;

  logic [LINE_BITS-1:0] r_mem [NUM_WAYS][NUM_SETS];

  logic [IDX-1:0]       w_rd_set, w_fill_set_in, w_fill_set;
  logic [WAY_W-1:0]     w_fill_way;
  logic [CNT_W-1:0]     w_cnt;
  logic [WSEL_W-1:0]    w_rd_word;
  logic                 w_beat_we, w_rd_acc;
  logic [LINE_BITS-1:0] w_line;
  logic [WORD_SIZE-1:0] w_rd_word_data;
  logic                 r_rd_valid;
  logic [WORD_SIZE-1:0] r_rd_data;
  logic                 w_unused_addr;

  assign w_rd_set      = rd_addr_i[OFF+IDX-1:OFF];
  assign w_fill_set_in = fill_addr_i[OFF+IDX-1:OFF];
  assign w_unused_addr = ^{rd_addr_i[WORD_SIZE-1:OFF+IDX], rd_addr_i[1:0],
                           fill_addr_i[WORD_SIZE-1:OFF+IDX], fill_addr_i[OFF-1:0]};

  if (OFF > 2) begin : g_wsel
    assign w_rd_word = rd_addr_i[OFF-1:2];
  end else begin : g_wsel_none
    assign w_rd_word = '0;
  end

  segre_icache_fill_fsm #(
    .SET_W (IDX),
    .WAY_W (WAY_W),
    .BEATS (BEATS)
  ) u_fill_fsm (
    .clk_i             (clk_i),
    .rst_i             (rst_i),
    .fill_start_i      (fill_start_i),
    .fill_set_i        (w_fill_set_in),
    .fill_way_i        (fill_way_i),
    .fill_beat_valid_i (fill_beat_valid_i),
    .fill_beat_ready_o (fill_beat_ready_o),
    .fill_done_o       (fill_done_o),
    .busy_o            (busy_o),
    .beat_we_o         (w_beat_we),
    .fill_set_o        (w_fill_set),
    .fill_way_o        (w_fill_way),
    .beat_cnt_o        (w_cnt)
  );

  // Only the line currently being filled is blocked; every other line reads freely.
  assign rd_ready_o = ~(fill_beat_ready_o && (w_rd_set == w_fill_set) && (rd_way_i == w_fill_way));
  assign w_rd_acc   = rd_req_i & rd_ready_o;

  always_ff @(posedge clk_i) begin
    if (w_beat_we) begin
      r_mem[w_fill_way][w_fill_set][w_cnt*FILL_BEAT_BITS +: FILL_BEAT_BITS] <= fill_beat_data_i;
    end
  end

  assign w_line         = r_mem[rd_way_i][w_rd_set];
  assign w_rd_word_data = w_line[w_rd_word*WORD_SIZE +: WORD_SIZE];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_rd_valid <= 1'b0;
      r_rd_data  <= '0;
    end else begin
      r_rd_valid <= w_rd_acc;
      if (w_rd_acc) r_rd_data <= w_rd_word_data;
    end
  end

  assign rd_valid_o = r_rd_valid;
  assign rd_data_o  = r_rd_data;

`ifdef SEGRE_ICACHE_PARITY_EN
  logic [LANE_BYTES-1:0] r_par [NUM_WAYS][NUM_SETS];
  logic [BEAT_BYTES-1:0] w_beat_par;
  logic [WORD_BYTES-1:0] w_rd_par_calc;
  logic [LANE_BYTES-1:0] w_par_line;
  logic                  w_par_mis;
  logic                  r_par_err;

  // Even parity: stored bit is the XOR of its byte.
  always_comb begin
    w_beat_par    = '0;
    w_rd_par_calc = '0;
    for (int b = 0; b < BEAT_BYTES; b++) w_beat_par[b]    = ^fill_beat_data_i[b*8 +: 8];
    for (int b = 0; b < WORD_BYTES; b++) w_rd_par_calc[b] = ^w_rd_word_data[b*8 +: 8];
  end

  always_ff @(posedge clk_i) begin
    if (w_beat_we) begin
      r_par[w_fill_way][w_fill_set][w_cnt*BEAT_BYTES +: BEAT_BYTES] <= w_beat_par;
    end
  end

  assign w_par_line = r_par[rd_way_i][w_rd_set];
  assign w_par_mis  = |(w_rd_par_calc ^ w_par_line[w_rd_word*WORD_BYTES +: WORD_BYTES]);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) r_par_err <= 1'b0;
    else       r_par_err <= w_rd_acc & w_par_mis;
  end

  assign parity_err_o = r_par_err;
`else
  assign parity_err_o = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_segre_icache_data_nway.sv
// +----------------------------------------------------------------------------
// | tb_segre_icache_data_nway : directed self-checking bench for the icache data array
// | rev 1.0
// +----------------------------------------------------------------------------
`default_nettype none

module tb_segre_icache_data_nway;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        rd_req_i;
  logic [31:0] rd_addr_i;
  logic [0:0]  rd_way_i;
  logic        rd_ready_o, rd_valid_o;
  logic [31:0] rd_data_o;
  logic        fill_start_i;
  logic [31:0] fill_addr_i;
  logic [0:0]  fill_way_i;
  logic        fill_beat_valid_i;
  logic [31:0] fill_beat_data_i;
  logic        fill_beat_ready_o, fill_done_o, busy_o, parity_err_o;

  int n_vec = 0;
  int n_err = 0;

  logic [31:0] l1 [4];
  logic [31:0] l2 [4];
  logic [31:0] l3 [4];

  segre_icache_data_nway dut (
    .clk_i             (clk_i),
    .rst_i             (rst_i),
    .rd_req_i          (rd_req_i),
    .rd_addr_i         (rd_addr_i),
    .rd_way_i          (rd_way_i),
    .rd_ready_o        (rd_ready_o),
    .rd_valid_o        (rd_valid_o),
    .rd_data_o         (rd_data_o),
    .fill_start_i      (fill_start_i),
    .fill_addr_i       (fill_addr_i),
    .fill_way_i        (fill_way_i),
    .fill_beat_valid_i (fill_beat_valid_i),
    .fill_beat_data_i  (fill_beat_data_i),
    .fill_beat_ready_o (fill_beat_ready_o),
    .fill_done_o       (fill_done_o),
    .busy_o            (busy_o),
    .parity_err_o      (parity_err_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  // Tasks are entered just after a falling edge and return just after one.
  task automatic rd_word(input string tag, input logic [31:0] addr, input logic way,
                         input logic [31:0] exp, input logic exp_par);
    rd_req_i = 1'b1; rd_addr_i = addr; rd_way_i = way;
    #1 chk({tag, "_ready"}, {31'd0, rd_ready_o}, 32'd1);
    @(negedge clk_i);
    rd_req_i = 1'b0;
    chk({tag, "_valid"}, {31'd0, rd_valid_o}, 32'd1);
    chk({tag, "_data"}, rd_data_o, exp);
    chk({tag, "_par"}, {31'd0, parity_err_o}, {31'd0, exp_par});
  endtask

  task automatic fill_line(input string tag, input logic [31:0] addr, input logic way,
                           input logic [31:0] b [4], input int gap, input bit poke_done);
    fill_start_i = 1'b1; fill_addr_i = addr; fill_way_i = way;
    @(negedge clk_i);
    fill_start_i = 1'b0;
    chk({tag, "_busy"}, {31'd0, busy_o}, 32'd1);
    for (int i = 0; i < 4; i++) begin
      fill_beat_valid_i = 1'b1; fill_beat_data_i = b[i];
      #1 chk({tag, "_bready"}, {31'd0, fill_beat_ready_o}, 32'd1);
      @(negedge clk_i);
      fill_beat_valid_i = 1'b0; fill_beat_data_i = '0;
      if (i < 3) begin
        chk({tag, "_nodone"}, {31'd0, fill_done_o}, 32'd0);
        for (int g = 0; g < gap; g++) begin
          chk({tag, "_gapbusy"}, {31'd0, busy_o}, 32'd1);
          @(negedge clk_i);
        end
      end
    end
    chk({tag, "_done"}, {31'd0, fill_done_o}, 32'd1);
    if (poke_done) begin
      fill_start_i = 1'b1; fill_addr_i = 32'h70; fill_way_i = 1'b0;
    end
    @(negedge clk_i);
    fill_start_i = 1'b0;
    chk({tag, "_done_end"}, {31'd0, fill_done_o}, 32'd0);
    chk({tag, "_idle"}, {31'd0, busy_o}, 32'd0);
  endtask

  initial begin
    l1[0] = 32'h03020100; l1[1] = 32'h07060504; l1[2] = 32'h0B0A0908; l1[3] = 32'h0F0E0D0C;
    l2[0] = 32'h13121110; l2[1] = 32'h17161514; l2[2] = 32'h1B1A1918; l2[3] = 32'h1F1E1D1C;
    l3[0] = 32'hDEADBEEF; l3[1] = 32'h01234567; l3[2] = 32'h89ABCDEF; l3[3] = 32'hCAFEF00D;

    rst_i = 1'b1; rd_req_i = 1'b0; rd_addr_i = '0; rd_way_i = '0;
    fill_start_i = 1'b0; fill_addr_i = '0; fill_way_i = '0;
    fill_beat_valid_i = 1'b0; fill_beat_data_i = '0;
    repeat (2) @(negedge clk_i);
    chk("rst_valid", {31'd0, rd_valid_o}, 32'd0);
    chk("rst_data", rd_data_o, 32'd0);
    chk("rst_done", {31'd0, fill_done_o}, 32'd0);
    chk("rst_bready", {31'd0, fill_beat_ready_o}, 32'd0);
    chk("rst_busy", {31'd0, busy_o}, 32'd0);
    chk("rst_par", {31'd0, parity_err_o}, 32'd0);
    rst_i = 1'b0;
    @(negedge clk_i);

    // Basic fill of set 3 way 1 and a word read
    fill_line("f_s3w1", 32'h30, 1'b1, l1, 0, 1'b0);
    rd_word("rd_38", 32'h38, 1'b1, 32'h0B0A0908, 1'b0);
    @(negedge clk_i);
    chk("rd_pulse", {31'd0, rd_valid_o}, 32'd0);
    chk("rd_hold", rd_data_o, 32'h0B0A0908);

    // Gapped fill of set 5 way 1; fill_start during DONE must be ignored
    fill_line("f_s5w1", 32'h50, 1'b1, l2, 2, 1'b1);

    // Back-to-back reads of all four words
    for (int i = 0; i < 4; i++) begin
      rd_req_i = 1'b1; rd_addr_i = 32'h50 + 32'(4 * i); rd_way_i = 1'b1;
      @(negedge clk_i);
      chk("b2b_valid", {31'd0, rd_valid_o}, 32'd1);
      chk("b2b_data", rd_data_o, l2[i]);
    end
    rd_req_i = 1'b0;
    @(negedge clk_i);
    chk("b2b_end", {31'd0, rd_valid_o}, 32'd0);

    // Refill of set 3 way 1 with reads to the blocked line and to other lines
    fill_start_i = 1'b1; fill_addr_i = 32'h30; fill_way_i = 1'b1;
    @(negedge clk_i);
    fill_start_i = 1'b0;
    for (int i = 0; i < 2; i++) begin
      fill_beat_valid_i = 1'b1; fill_beat_data_i = l3[i];
      @(negedge clk_i);
      fill_beat_valid_i = 1'b0;
    end
    rd_req_i = 1'b1; rd_addr_i = 32'h3C; rd_way_i = 1'b1;
    #1 chk("blk_ready", {31'd0, rd_ready_o}, 32'd0);
    @(negedge clk_i);
    rd_req_i = 1'b0;
    chk("blk_valid", {31'd0, rd_valid_o}, 32'd0);
    rd_word("oth_s5w1", 32'h54, 1'b1, l2[1], 1'b0);
    rd_req_i = 1'b1; rd_addr_i = 32'h30; rd_way_i = 1'b0;
    #1 chk("oth_s3w0_ready", {31'd0, rd_ready_o}, 32'd1);
    @(negedge clk_i);
    rd_req_i = 1'b0;
    chk("oth_s3w0_valid", {31'd0, rd_valid_o}, 32'd1);
    chk("refill_busy", {31'd0, busy_o}, 32'd1);
    for (int i = 2; i < 4; i++) begin
      fill_beat_valid_i = 1'b1; fill_beat_data_i = l3[i];
      @(negedge clk_i);
      fill_beat_valid_i = 1'b0;
    end
    chk("refill_done", {31'd0, fill_done_o}, 32'd1);
    @(negedge clk_i);
    rd_word("refill_w3", 32'h3C, 1'b1, l3[3], 1'b0);
    rd_word("refill_w0", 32'h30, 1'b1, l3[0], 1'b0);

    // Reset in the middle of a fill, with a read accepted in the same cycle
    fill_start_i = 1'b1; fill_addr_i = 32'h70; fill_way_i = 1'b0;
    @(negedge clk_i);
    fill_start_i = 1'b0;
    for (int i = 0; i < 2; i++) begin
      fill_beat_valid_i = 1'b1; fill_beat_data_i = l1[i];
      @(negedge clk_i);
      fill_beat_valid_i = 1'b0;
    end
    rd_req_i = 1'b1; rd_addr_i = 32'h54; rd_way_i = 1'b1; rst_i = 1'b1;
    #1 chk("mrst_busy", {31'd0, busy_o}, 32'd0);
    chk("mrst_bready", {31'd0, fill_beat_ready_o}, 32'd0);
    chk("mrst_done", {31'd0, fill_done_o}, 32'd0);
    @(negedge clk_i);
    chk("mrst_rdvalid", {31'd0, rd_valid_o}, 32'd0);
    chk("mrst_rddata", rd_data_o, 32'd0);
    rd_req_i = 1'b0; rst_i = 1'b0;
    fill_line("f_after_rst", 32'h70, 1'b0, l2, 0, 1'b0);
    rd_word("after_rst_w3", 32'h7C, 1'b0, l2[3], 1'b0);

`ifdef SEGRE_ICACHE_PARITY_EN
    dut.r_mem[1][5][40] = ~dut.r_mem[1][5][40];
    rd_word("par_flip", 32'h54, 1'b1, l2[1] ^ 32'h0000_0100, 1'b1);
    rd_word("par_clean", 32'h58, 1'b1, l2[2], 1'b0);
`else
    rd_word("par_off", 32'h58, 1'b1, l2[2], 1'b0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/segre_icache_data_nway.md
Name: segre_icache_data_nway

Overview:
N-way set-associative instruction-cache data array. It supersedes the single-way, single-cycle-fill data store.
- Lines are filled from the MMU in multiple beats under a fill FSM.
- Fetch reads are word-granular and return one cycle after acceptance.
- Sits between the icache tag/control logic (which supplies hit way and set) and the fetch stage.
- Optional per-byte parity protection.

Parameters:
WORD_SIZE, 32, fetch word width in bits
NUM_WAYS, 2, associativity (power of 2, >=1)
NUM_SETS, 16, sets per way (power of 2)
LANE_BYTES, 16, bytes per line (power of 2, >=4)
FILL_BEAT_BITS, 32, MMU fill beat width; LANE_BYTES*8 must be a multiple of it

Ports:
clk_i  in  1  clock, all logic on rising edge
rst_i  in  1  asynchronous, active-high reset
rd_req_i  in  1  fetch read request
rd_addr_i  in  WORD_SIZE  fetch byte address; set = addr[OFF+IDX-1:OFF], word = addr[OFF-1:2], bits[1:0] ignored
rd_way_i  in  $clog2(NUM_WAYS) (min 1)  hit way from tag logic
rd_ready_o  out  1  read may be accepted this cycle
rd_valid_o  out  1  rd_data_o valid (one-cycle pulse per accepted read)
rd_data_o  out  WORD_SIZE  fetched word, little-endian byte order
fill_start_i  in  1  begin line fill
fill_addr_i  in  WORD_SIZE  address of line to fill (offset bits ignored)
fill_way_i  in  $clog2(NUM_WAYS) (min 1)  victim way
fill_beat_valid_i  in  1  MMU beat valid
fill_beat_data_i  in  FILL_BEAT_BITS  beat payload, beat 0 = lowest bytes
fill_beat_ready_o  out  1  beat accepted when valid && ready
fill_done_o  out  1  one-cycle pulse after last beat written
busy_o  out  1  FSM not IDLE
parity_err_o  out  1  parity mismatch on read (tied 0 without macro)

Behaviour:
- Reset: rst_i is asynchronous and active-high. Outputs on reset: rd_valid_o=0, rd_data_o=0, fill_done_o=0, fill_beat_ready_o=0, busy_o=0, parity_err_o=0. FSM resets to IDLE, beat counter to 0. Data array is not reset; contents are undefined until filled.
- BEATS = LANE_BYTES*8/FILL_BEAT_BITS. Beat counter width is clog2(BEATS) (min 1).
- FSM states IDLE, FILL, DONE:
  - IDLE: fill_start_i=1 latches set and way, clears the counter, goes to FILL. fill_start_i in FILL or DONE is ignored.
  - FILL: fill_beat_ready_o=1. An accepted beat writes bytes [cnt*FILL_BEAT_BITS/8 +: FILL_BEAT_BITS/8] of the latched line at the clock edge, then cnt++. Acceptance of beat BEATS-1 goes to DONE. No timeout; FILL waits indefinitely for valid.
  - DONE: fill_done_o=1 for exactly one cycle, then IDLE.
- Read handshake:
  - rd_ready_o=0 only when the FSM is in FILL and the read set and way equal the latched fill set and way. Otherwise rd_ready_o=1, including DONE and fills to other lines.
  - An accepted read (rd_req_i && rd_ready_o) samples the array at edge N. rd_valid_o=1 with data in cycle N+1.
  - rd_data_o holds its last value while rd_valid_o=0.
  - Back-to-back reads are supported at one per cycle.
- Same-edge fill write and read of a different line: independent, no interaction.
- Reset mid-fill: FSM returns to IDLE with no fill_done_o. The partially written line is undefined; tag logic must not mark it valid.
- Accepted read and reset in the same cycle: rd_valid_o stays 0.

Optional Feature:
SEGRE_ICACHE_PARITY_EN
- Defined:
  - One even-parity bit is stored per data byte, written alongside each fill beat.
  - On a read, parity is recomputed over the 4 fetched bytes. parity_err_o=1 in the rd_valid_o cycle if any byte mismatches.
  - Data is still returned unmodified.
- Undefined: no parity storage; parity_err_o tied to 0.

Decomposition:
- segre_pkg gains:
  - ICACHE_NUM_WAYS, ICACHE_NUM_SETS, ICACHE_LANE_BYTES, ICACHE_FILL_BEAT_BITS
  - derived ICACHE_OFFSET_SIZE, ICACHE_INDEX_SIZE
  - typedef enum icache_fill_state_e {IFILL_IDLE, IFILL_FILL, IFILL_DONE}
- Sub-module segre_icache_fill_fsm holds the FSM, beat counter, latched set/way, and fill_done/busy/ready generation. The top holds the storage array, read port and parity.

Test Plan:
- Defaults. Fill set 3 way 1 with beats 0x03020100, 0x07060504, 0x0B0A0908, 0x0F0E0D0C (valid every cycle). Then read 0x38 way 1 -> fill_done_o pulses 1 cycle after beat 3; rd_valid_o next cycle with rd_data_o=0x0B0A0908.
- Fill with fill_beat_valid_i gaps of 2 cycles -> counter advances only on valid&&ready; exactly 4 writes; busy_o=1 throughout.
- During FILL of set 3 way 1: read set 3 way 1 -> rd_ready_o=0. Read set 3 way 0 and set 5 way 1 -> rd_ready_o=1, data returned next cycle.
- Assert rst_i after beat 1 of a fill -> busy_o=0 and no fill_done_o. A subsequent fill_start_i is accepted in the first cycle after reset release.
- Back-to-back reads of words 0..3 of a filled line on consecutive cycles -> rd_valid_o high 4 consecutive cycles, data in order. fill_start_i in DONE is ignored.
- With SEGRE_ICACHE_PARITY_EN, force-flip one stored data bit via hierarchical access -> parity_err_o=1 on that read only. Without the macro -> parity_err_o=0 always.
